// File: rtl/seq_watch_pkg.sv
// Shared types and default pattern constants for the seq_watch monitor.
package seq_watch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2
  } state_t;

  localparam logic [2:0] P0_DEF    = 3'd2;
  localparam logic [2:0] P1_DEF    = 3'd3;
  localparam logic [2:0] P2_DEF    = 3'd4;
  localparam int         CNT_W_DEF = 4;

endpackage

// File: rtl/seq_step_detect.sv
// Step classifier for the 3-bit counter stream: tracks the previous value,
// registers step direction, and (with SEQ_WATCH_ERR_EN) a sticky illegal-step flag.
module seq_step_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] qf,
  output logic       step,
  output logic       dir,
  output logic       dir_valid,
  output logic       err
);

  logic [2:0] q_prev;
  logic [2:0] q_inc;
  logic [2:0] q_dec;
  logic       up;
  logic       down;

  // 3-bit arithmetic gives the mod-8 wrap for free
  assign q_inc = q_prev + 3'd1;
  assign q_dec = q_prev - 3'd1;
  assign up    = (qf == q_inc);
  assign down  = (qf == q_dec);
  assign step  = (qf != q_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev    <= 3'd0;
      dir       <= 1'b0;
      dir_valid <= 1'b0;
    end else begin
      q_prev    <= qf;
      dir_valid <= up | down;
      if (up | down) dir <= up;
    end
  end

`ifdef SEQ_WATCH_ERR_EN
  logic illegal;

  assign illegal = step & ~up & ~down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/seq_watch.sv
// Pattern monitor for the up/down sequence counter: three-code match FSM,
// registered hit pulse and saturating hit counter. Optional macro: SEQ_WATCH_ERR_EN.
module seq_watch
  import seq_watch_pkg::*;
#(
  parameter logic [2:0] P0    = P0_DEF,
  parameter logic [2:0] P1    = P1_DEF,
  parameter logic [2:0] P2    = P2_DEF,
  parameter int         CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       qf,
  output logic             dir,
  output logic             dir_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             err
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t state;
  state_t state_nxt;
  logic   step;
  logic   adv;
  logic   complete;

  seq_step_detect u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .qf        (qf),
    .step      (step),
    .dir       (dir),
    .dir_valid (dir_valid),
    .err       (err)
  );

  assign adv = en & step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A fresh P0 always restarts the match, which is what allows overlaps
  always_comb begin
    state_nxt = state;
    if (adv) begin
      case (state)
        IDLE:    state_nxt = (qf == P0) ? GOT0 : IDLE;
        GOT0: begin
          if      (qf == P1) state_nxt = GOT1;
          else if (qf == P0) state_nxt = GOT0;
          else               state_nxt = IDLE;
        end
        GOT1: begin
          if      (qf == P2) state_nxt = (P2 == P0) ? GOT0 : IDLE;
          else if (qf == P0) state_nxt = GOT0;
          else               state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    complete = adv && (state == GOT1) && (qf == P2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      hit <= complete;
      if (complete) hit_cnt <= sat_inc(hit_cnt);
    end
  end

endmodule
